// File: rtl/arbitro_memoria.sv
// Arbitrates one data memory between the pipeline MEM stage (p_) and a DMA/I-O port (d_).
// Optional round-robin tie-breaking is enabled by defining ARB_RR_EN; otherwise the pipeline wins ties.
module arbitro_memoria #(
  parameter int LARGURA_DADOS = 32,
  parameter int LARGURA_END   = 32,
  parameter int LATENCIA      = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     p_req,
  input  logic                     p_escrever,
  input  logic [LARGURA_END-1:0]   p_endereco,
  input  logic [LARGURA_DADOS-1:0] p_valor,
  output logic                     p_pronto,
  output logic [LARGURA_DADOS-1:0] p_dado,
  input  logic                     d_req,
  input  logic                     d_escrever,
  input  logic [LARGURA_END-1:0]   d_endereco,
  input  logic [LARGURA_DADOS-1:0] d_valor,
  output logic                     d_pronto,
  output logic [LARGURA_DADOS-1:0] d_dado,
  output logic [LARGURA_END-1:0]   memEndereco,
  output logic [LARGURA_DADOS-1:0] memValor,
  output logic                     escreverMemoria,
  output logic                     lerMemoria,
  input  logic [LARGURA_DADOS-1:0] saida,
  output logic                     ocupado,
  output logic [1:0]               o_estado,
  output logic                     o_ultimo
);

  // Handshake: a requester raises req (with escrever/endereco/valor stable) and holds it
  // until its pronto pulses for one cycle; inputs are only sampled while the arbiter is idle.

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] ACESSO  = 2'd1;
  localparam logic [1:0] CONCLUI = 2'd2;

  localparam logic PORTA_P = 1'b0;
  localparam logic PORTA_D = 1'b1;

  localparam int CW = (LATENCIA < 1) ? 1 : $clog2(LATENCIA + 1);

  if (LATENCIA < 1) begin : g_latencia_invalida
    $error("arbitro_memoria: LATENCIA must be at least 1");
  end

  logic [1:0]               r_estado;
  logic [CW-1:0]            r_cont;
  logic                     r_escrever;
  logic                     r_ganho;
  logic                     r_ultimo;
  logic [LARGURA_END-1:0]   r_end;
  logic [LARGURA_DADOS-1:0] r_valor;
  logic                     r_p_pronto;
  logic                     r_d_pronto;
  logic [LARGURA_DADOS-1:0] r_p_dado;
  logic [LARGURA_DADOS-1:0] r_d_dado;

  logic w_req;
  logic w_grant_d;
  logic w_fim;

  assign w_req = p_req | d_req;
  assign w_fim = (r_estado == ACESSO) && (r_cont == '0);

`ifdef ARB_RR_EN
  // On a tie, the port that was not served last gets the memory.
  assign w_grant_d = d_req && (!p_req || (r_ultimo == PORTA_P));
`else
  assign w_grant_d = d_req && !p_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_cont     <= '0;
      r_escrever <= 1'b0;
      r_ganho    <= PORTA_P;
      r_ultimo   <= PORTA_D;
      r_end      <= '0;
      r_valor    <= '0;
      r_p_pronto <= 1'b0;
      r_d_pronto <= 1'b0;
      r_p_dado   <= '0;
      r_d_dado   <= '0;
    end else begin
      r_p_pronto <= 1'b0;
      r_d_pronto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (w_req) begin
            r_estado   <= ACESSO;
            r_ganho    <= w_grant_d;
            r_ultimo   <= w_grant_d;
            r_escrever <= w_grant_d ? d_escrever : p_escrever;
            r_end      <= w_grant_d ? d_endereco : p_endereco;
            r_valor    <= w_grant_d ? d_valor : p_valor;
            r_cont     <= CW'(LATENCIA - 1);
          end
        end
        ACESSO: begin
          if (r_cont == '0) begin
            r_estado <= CONCLUI;
            if (r_ganho == PORTA_D) begin
              r_d_pronto <= 1'b1;
              if (!r_escrever) r_d_dado <= saida;
            end else begin
              r_p_pronto <= 1'b1;
              if (!r_escrever) r_p_dado <= saida;
            end
          end else begin
            r_cont <= r_cont - CW'(1);
          end
        end
        CONCLUI: r_estado <= OCIOSO;
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  // Strobes decode registered state only, so they are glitch-free and never overlap.
  assign lerMemoria      = (r_estado == ACESSO) && !r_escrever;
  assign escreverMemoria = w_fim && r_escrever;

  assign memEndereco = r_end;
  assign memValor    = r_valor;
  assign p_pronto    = r_p_pronto;
  assign d_pronto    = r_d_pronto;
  assign p_dado      = r_p_dado;
  assign d_dado      = r_d_dado;
  assign ocupado     = (r_estado != OCIOSO);
  assign o_estado    = r_estado;
  assign o_ultimo    = r_ultimo;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: memory model, read-data scoreboard, grant order and latency builds.
module tb_arbitro_memoria;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p_req = 1'b0, p_escrever = 1'b0;
  logic [31:0] p_endereco = '0, p_valor = '0;
  logic        d_req = 1'b0, d_escrever = 1'b0;
  logic [31:0] d_endereco = '0, d_valor = '0;
  logic        p_pronto, d_pronto;
  logic [31:0] p_dado, d_dado;
  logic [31:0] memEndereco, memValor;
  logic        escreverMemoria, lerMemoria;
  logic [31:0] saida;
  logic        ocupado;
  logic [1:0]  o_estado;
  logic        o_ultimo;

  logic [31:0] mem [0:15];
  logic [31:0] ref_mem [0:15];
  logic [31:0] exp_q [$];
  logic [31:0] grant_q [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  arbitro_memoria #(.LARGURA_DADOS(32), .LARGURA_END(32), .LATENCIA(LAT)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_escrever(p_escrever), .p_endereco(p_endereco), .p_valor(p_valor),
    .p_pronto(p_pronto), .p_dado(p_dado),
    .d_req(d_req), .d_escrever(d_escrever), .d_endereco(d_endereco), .d_valor(d_valor),
    .d_pronto(d_pronto), .d_dado(d_dado),
    .memEndereco(memEndereco), .memValor(memValor),
    .escreverMemoria(escreverMemoria), .lerMemoria(lerMemoria), .saida(saida),
    .ocupado(ocupado), .o_estado(o_estado), .o_ultimo(o_ultimo)
  );

  // Memory device: combinational read, write on the strobe edge.
  always_comb saida = mem[memEndereco[3:0]];
  always @(posedge clock) if (escreverMemoria) mem[memEndereco[3:0]] <= memValor;

  // Latency-1 and latency-4 builds, driven by a constant-output memory.
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = '0;
  logic [31:0] cte = 32'h0000_00A5;
  logic        l1_req = 1'b0, l4_req = 1'b0;
  logic        l1_pp, l1_dp, l1_we, l1_re, l1_oc, l1_ul;
  logic [31:0] l1_pd, l1_dd, l1_me, l1_mv;
  logic [1:0]  l1_es;
  logic        l4_pp, l4_dp, l4_we, l4_re, l4_oc, l4_ul;
  logic [31:0] l4_pd, l4_dd, l4_me, l4_mv;
  logic [1:0]  l4_es;

  arbitro_memoria #(.LARGURA_DADOS(32), .LARGURA_END(32), .LATENCIA(1)) dut_l1 (
    .clock(clock), .reset(reset),
    .p_req(l1_req), .p_escrever(zero1), .p_endereco(zero32), .p_valor(zero32),
    .p_pronto(l1_pp), .p_dado(l1_pd),
    .d_req(zero1), .d_escrever(zero1), .d_endereco(zero32), .d_valor(zero32),
    .d_pronto(l1_dp), .d_dado(l1_dd),
    .memEndereco(l1_me), .memValor(l1_mv),
    .escreverMemoria(l1_we), .lerMemoria(l1_re), .saida(cte),
    .ocupado(l1_oc), .o_estado(l1_es), .o_ultimo(l1_ul)
  );

  arbitro_memoria #(.LARGURA_DADOS(32), .LARGURA_END(32), .LATENCIA(4)) dut_l4 (
    .clock(clock), .reset(reset),
    .p_req(l4_req), .p_escrever(zero1), .p_endereco(zero32), .p_valor(zero32),
    .p_pronto(l4_pp), .p_dado(l4_pd),
    .d_req(zero1), .d_escrever(zero1), .d_endereco(zero32), .d_valor(zero32),
    .d_pronto(l4_dp), .d_dado(l4_dd),
    .memEndereco(l4_me), .memValor(l4_mv),
    .escreverMemoria(l4_we), .lerMemoria(l4_re), .saida(cte),
    .ocupado(l4_oc), .o_estado(l4_es), .o_ultimo(l4_ul)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access through the main DUT; mexe alters the requester's inputs during ACESSO.
  task automatic access(input bit porta, input bit wr, input logic [3:0] addr,
                        input logic [31:0] val, input bit mexe);
    int n_w, w_cyc, n_r, cyc_pronto;
    bit outro;
    @(negedge clock);
    if (porta == 1'b0) begin
      p_req = 1'b1; p_escrever = wr; p_endereco = {28'd0, addr}; p_valor = val;
    end else begin
      d_req = 1'b1; d_escrever = wr; d_endereco = {28'd0, addr}; d_valor = val;
    end
    if (wr) ref_mem[addr] = val;
    else exp_q.push_back(ref_mem[addr]);
    @(posedge clock);
    n_w = 0; w_cyc = 0; n_r = 0; cyc_pronto = 0; outro = 1'b0;
    for (int c = 1; c <= LAT + 3 && cyc_pronto == 0; c++) begin
      @(negedge clock);
      if (mexe && c == 1) begin
        if (porta == 1'b0) begin p_endereco = p_endereco + 32'd1; p_valor = ~p_valor; end
        else begin d_endereco = d_endereco + 32'd1; d_valor = ~d_valor; end
      end
      if (escreverMemoria) begin n_w++; w_cyc = c; end
      if (lerMemoria) n_r++;
      if (c == 1) check("ocupado", {31'd0, ocupado}, 32'd1);
      if (c == 1 || c == LAT) begin
        check("mem_endereco", memEndereco, {28'd0, addr});
        check("mem_valor", memValor, val);
      end
      if (porta == 1'b0 ? d_pronto : p_pronto) outro = 1'b1;
      if (porta == 1'b0 ? p_pronto : d_pronto) cyc_pronto = c;
    end
    check("pronto_ciclo", cyc_pronto, LAT + 1);
    check("outro_pronto", {31'd0, outro}, 32'd0);
    check("n_escrita", n_w, wr ? 32'd1 : 32'd0);
    if (wr) check("ciclo_escrita", w_cyc, LAT);
    check("n_leitura", n_r, wr ? 32'd0 : LAT);
    if (!wr && exp_q.size() > 0) check("dado", porta ? d_dado : p_dado, exp_q.pop_front());
    p_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, c1, c4, prev, cyc;
    logic [31:0] g;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_mem_end", memEndereco, 32'd0);
    check("rst_mem_val", memValor, 32'd0);
    check("rst_strobes", {30'd0, escreverMemoria, lerMemoria}, 32'd0);
    check("rst_pronto", {30'd0, p_pronto, d_pronto}, 32'd0);
    check("rst_p_dado", p_dado, 32'd0);
    check("rst_d_dado", d_dado, 32'd0);
    check("rst_ocupado", {31'd0, ocupado}, 32'd0);
    check("rst_ultimo", {31'd0, o_ultimo}, 32'd1);
    reset = 1'b0;

    // Pipeline write then read, DMA read, second pattern
    access(1'b0, 1'b1, 4'd1, 32'd100, 1'b0);
    access(1'b0, 1'b0, 4'd1, 32'd0, 1'b0);
    access(1'b1, 1'b0, 4'd1, 32'd0, 1'b0);
    check("p_dado_mantido", p_dado, 32'd100);
    access(1'b1, 1'b1, 4'd2, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b0, 4'd2, 32'd0, 1'b0);

    for (int i = 0; i < 6; i++)
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), $urandom, 1'b0);

    // Inputs changed during ACESSO must not reach the memory
    access(1'b0, 1'b1, 4'd3, 32'h0000_0033, 1'b1);
    access(1'b1, 1'b1, 4'd7, 32'h0000_0077, 1'b1);
    access(1'b0, 1'b0, 4'd3, 32'd0, 1'b0);
    access(1'b0, 1'b0, 4'd4, 32'd0, 1'b0);
    access(1'b1, 1'b0, 4'd8, 32'd0, 1'b0);

    // Reset in the first ACESSO cycle of a write
    @(negedge clock);
    p_req = 1'b1; p_escrever = 1'b1; p_endereco = 32'd5; p_valor = 32'd7;
    @(posedge clock);
    @(negedge clock);
    check("rst_meio_sem_escrita", {31'd0, escreverMemoria}, 32'd0);
    reset = 1'b1; p_req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_meio_mem_end", memEndereco, 32'd0);
    check("rst_meio_mem_val", memValor, 32'd0);
    check("rst_meio_strobes", {30'd0, escreverMemoria, lerMemoria}, 32'd0);
    check("rst_meio_pronto", {30'd0, p_pronto, d_pronto}, 32'd0);
    check("rst_meio_p_dado", p_dado, 32'd0);
    check("rst_meio_d_dado", d_dado, 32'd0);
    check("rst_meio_ocupado", {31'd0, ocupado}, 32'd0);
    ng = 0;
    repeat (4) begin @(negedge clock); if (escreverMemoria) ng++; end
    check("rst_meio_escritas", ng, 32'd0);
    access(1'b0, 1'b0, 4'd5, 32'd0, 1'b0);

    // Both requests held high from reset: grant order and back-to-back spacing
    @(negedge clock);
    reset = 1'b1;
    p_req = 1'b1; p_escrever = 1'b0; p_endereco = 32'd1;
    d_req = 1'b1; d_escrever = 1'b0; d_endereco = 32'd2;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      grant_q.push_back(32'(i % 2));
`else
      grant_q.push_back(32'd0);
`endif
    end
    @(negedge clock);
    reset = 1'b0;
    ng = 0; prev = 0; cyc = 0;
    while (ng < 4 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (p_pronto || d_pronto) begin
        check("pronto_exclusivo", {30'd0, p_pronto, d_pronto} & 32'h3, p_pronto ? 32'd2 : 32'd1);
        g = d_pronto ? 32'd1 : 32'd0;
        if (grant_q.size() > 0) check("ordem_grant", g, grant_q.pop_front());
        if (ng > 0) check("espacamento", cyc - prev, LAT + 2);
        prev = cyc;
        ng++;
      end
    end
    check("n_grants", ng, 32'd4);
    p_req = 1'b0; d_req = 1'b0;

    // Latency-1 and latency-4 builds
    repeat (3) @(negedge clock);
    l1_req = 1'b1; l4_req = 1'b1;
    @(posedge clock);
    c1 = 0; c4 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (l1_pp && c1 == 0) begin c1 = c; l1_req = 1'b0; check("l1_dado", l1_pd, 32'h0000_00A5); end
      if (l4_pp && c4 == 0) begin c4 = c; l4_req = 1'b0; check("l4_dado", l4_pd, 32'h0000_00A5); end
    end
    check("l1_pronto_ciclo", c1, 32'd2);
    check("l4_pronto_ciclo", c4, 32'd5);
    l1_req = 1'b0; l4_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
